// File: rtl/bcd_run_ctrl.sv
// Run/stop/clear sequencer for the two-digit BCD counter: edge-detects the
// debounced buttons, prescales clk into count ticks and halts at the terminal value.
module bcd_run_ctrl #(
  parameter int TICK_DIV = 50000000,
  parameter int DIV_W    = 26
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_ss,
  input  logic       btn_clr,
  input  logic       cnt_max,
  output logic       cnt_en,
  output logic       cnt_clr,
  output logic       running,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    DONE  = 2'b11
  } state_t;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  state_t           state_q, state_d;
  logic             ss_q, clr_q;
  logic             ss_rise, clr_rise, tick;
  logic [DIV_W-1:0] div_cnt, div_d;
  logic             cnt_en_d, cnt_clr_d;

  assign ss_rise  = btn_ss & ~ss_q;
  assign clr_rise = btn_clr & ~clr_q;
  assign tick     = (state_q == RUN) && (div_cnt == DIV_LAST);

  // History resets high so a button held across reset release is not an event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_q  <= 1'b1;
      clr_q <= 1'b1;
    end else begin
      ss_q  <= btn_ss;
      clr_q <= btn_clr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      div_cnt <= '0;
      cnt_en  <= 1'b0;
      cnt_clr <= 1'b0;
    end else begin
      state_q <= state_d;
      div_cnt <= div_d;
      cnt_en  <= cnt_en_d;
      cnt_clr <= cnt_clr_d;
    end
  end

  // Clear outranks everything; in RUN a stop press outranks reaching DONE.
  always_comb begin
    state_d   = state_q;
    div_d     = div_cnt;
    cnt_en_d  = 1'b0;
    cnt_clr_d = 1'b0;
    if (clr_rise) begin
      state_d   = IDLE;
      div_d     = '0;
      cnt_clr_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          div_d = '0;
          if (ss_rise) state_d = RUN;
        end
        RUN: begin
          div_d = tick ? '0 : div_cnt + DIV_ONE;
          if (tick && !cnt_max) cnt_en_d = 1'b1;
          if (ss_rise)                state_d = PAUSE;
          else if (tick && cnt_max)   state_d = DONE;
        end
        PAUSE: begin
          if (ss_rise) state_d = RUN;
        end
        DONE: begin
          div_d = '0;
        end
        default: begin
          state_d = IDLE;
          div_d   = '0;
        end
      endcase
    end
  end

  assign running = (state_q == RUN);
  assign state   = state_q;

endmodule

// File: tb/tb_bcd_run_ctrl.sv
// Directed bench for bcd_run_ctrl with TICK_DIV=4: reset, run cadence, pause
// phase, terminal stop, clear priority and asynchronous reset mid-run.
module tb_bcd_run_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_ss, btn_clr, cnt_max;
  logic       cnt_en, cnt_clr, running;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  bcd_run_ctrl #(.TICK_DIV(4), .DIV_W(3)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_ss  (btn_ss),
    .btn_clr (btn_clr),
    .cnt_max (cnt_max),
    .cnt_en  (cnt_en),
    .cnt_clr (cnt_clr),
    .running (running),
    .state   (state)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; btn_ss = 1'b1; btn_clr = 1'b0; cnt_max = 1'b0;
    step(); step();
    checks++;
    if ({state, cnt_en, cnt_clr, running} !== 5'b00000) begin
      errors++;
      $display("FAIL reset_outputs got state=%b en=%b clr=%b run=%b want 00 0 0 0",
               state, cnt_en, cnt_clr, running);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if (state !== 2'b00 || cnt_en !== 1'b0) begin
        errors++;
        $display("FAIL held_ss_release cyc=%0d got state=%b en=%b want 00 0", i, state, cnt_en);
      end
    end
    btn_ss = 1'b0;
    step();
  endtask

  task automatic test_run();
    btn_ss = 1'b1;
    step();
    btn_ss = 1'b0;
    checks++;
    if (state !== 2'b01 || running !== 1'b1) begin
      errors++;
      $display("FAIL start got state=%b run=%b want 01 1", state, running);
    end
    for (int i = 1; i <= 40; i++) begin
      step();
      checks++;
      if (cnt_en !== ((i % 4) == 0)) begin
        errors++;
        $display("FAIL run_cadence cyc=%0d got en=%b want %b", i, cnt_en, (i % 4) == 0);
      end
    end
  endtask

  task automatic test_pause();
    step();
    btn_ss = 1'b1;
    step();
    btn_ss = 1'b0;
    checks++;
    if (state !== 2'b10 || cnt_en !== 1'b0 || running !== 1'b0) begin
      errors++;
      $display("FAIL pause_enter got state=%b en=%b run=%b want 10 0 0", state, cnt_en, running);
    end
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (state !== 2'b10 || cnt_en !== 1'b0) begin
        errors++;
        $display("FAIL pause_hold cyc=%0d got state=%b en=%b want 10 0", i, state, cnt_en);
      end
    end
    btn_ss = 1'b1;
    step();
    btn_ss = 1'b0;
    checks++;
    if (state !== 2'b01 || cnt_en !== 1'b0) begin
      errors++;
      $display("FAIL resume got state=%b en=%b want 01 0", state, cnt_en);
    end
    step();
    checks++;
    if (cnt_en !== 1'b0) begin
      errors++;
      $display("FAIL resume_phase1 got en=%b want 0", cnt_en);
    end
    step();
    checks++;
    if (cnt_en !== 1'b1) begin
      errors++;
      $display("FAIL resume_phase2 got en=%b want 1", cnt_en);
    end
  endtask

  task automatic test_done();
    cnt_max = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      checks++;
      if (state !== 2'b01 || cnt_en !== 1'b0) begin
        errors++;
        $display("FAIL pre_done cyc=%0d got state=%b en=%b want 01 0", i, state, cnt_en);
      end
    end
    step();
    checks++;
    if (state !== 2'b11 || cnt_en !== 1'b0) begin
      errors++;
      $display("FAIL done_enter got state=%b en=%b want 11 0", state, cnt_en);
    end
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (state !== 2'b11 || cnt_en !== 1'b0) begin
        errors++;
        $display("FAIL done_hold cyc=%0d got state=%b en=%b want 11 0", i, state, cnt_en);
      end
    end
    btn_ss = 1'b1;
    step();
    btn_ss = 1'b0;
    step();
    checks++;
    if (state !== 2'b11) begin
      errors++;
      $display("FAIL done_ignores_ss got state=%b want 11", state);
    end
    btn_clr = 1'b1;
    step();
    btn_clr = 1'b0;
    checks++;
    if (state !== 2'b00 || cnt_clr !== 1'b1) begin
      errors++;
      $display("FAIL done_clear got state=%b clr=%b want 00 1", state, cnt_clr);
    end
    step();
    checks++;
    if (state !== 2'b00 || cnt_clr !== 1'b0) begin
      errors++;
      $display("FAIL clear_width got state=%b clr=%b want 00 0", state, cnt_clr);
    end
    cnt_max = 1'b0;
  endtask

  task automatic test_clear_priority();
    btn_ss = 1'b1;
    step();
    btn_ss = 1'b0;
    step(); step(); step();
    // Prescaler now sits at its last count: the next edge would also tick.
    btn_ss = 1'b1; btn_clr = 1'b1;
    step();
    btn_ss = 1'b0; btn_clr = 1'b0;
    checks++;
    if (state !== 2'b00 || cnt_clr !== 1'b1 || cnt_en !== 1'b0) begin
      errors++;
      $display("FAIL simul_press got state=%b clr=%b en=%b want 00 1 0", state, cnt_clr, cnt_en);
    end
    step();
    checks++;
    if (state !== 2'b00 || cnt_clr !== 1'b0 || cnt_en !== 1'b0) begin
      errors++;
      $display("FAIL simul_after got state=%b clr=%b en=%b want 00 0 0", state, cnt_clr, cnt_en);
    end
  endtask

  task automatic test_async_reset();
    btn_ss = 1'b1;
    step();
    btn_ss = 1'b0;
    step(); step(); step();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({state, cnt_en, cnt_clr, running} !== 5'b00000) begin
      errors++;
      $display("FAIL async_reset got state=%b en=%b clr=%b run=%b want 00 0 0 0",
               state, cnt_en, cnt_clr, running);
    end
    step();
    rst_n = 1'b1;
    step();
    checks++;
    if (state !== 2'b00 || cnt_en !== 1'b0 || cnt_clr !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got state=%b en=%b clr=%b want 00 0 0", state, cnt_en, cnt_clr);
    end
    btn_ss = 1'b1;
    step();
    btn_ss = 1'b0;
    checks++;
    if (state !== 2'b01) begin
      errors++;
      $display("FAIL restart got state=%b want 01", state);
    end
    for (int i = 1; i <= 4; i++) begin
      step();
      checks++;
      if (cnt_en !== (i == 4)) begin
        errors++;
        $display("FAIL restart_phase cyc=%0d got en=%b want %b", i, cnt_en, i == 4);
      end
    end
  endtask

  initial begin
    test_reset();
    test_run();
    test_pause();
    test_done();
    test_clear_priority();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
